// File: rtl/instr_sequencer_if.sv
// Memory bus between the instruction sequencer and unified memory.
// The sequencer is master; mem_ready completes the current access.
interface instr_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [15:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_rd_en,
    output mem_wr_en,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    input  mem_wr_en,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Optional SEQ_RETIRE_COUNT_EN adds a retired-instruction counter.
module instr_sequencer #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  instr_sequencer_if.master bus,
  input  logic [15:0]       addr_reg_data,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [7:0]        immediate,
  output logic              use_imm,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [15:0]       load_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  state_t      state;
  logic [15:0] ir;
  logic        st_op;
  logic        rd_q;
  logic        wr_q;

  logic        cls_r;
  logic        cls_m;
  logic        cls_i;
  logic        is_ld;
  logic        is_st;
  logic        is_nop;
  logic        retire;

  always_comb begin
    cls_r  = (ir[15:12] == 4'h0);
    cls_m  = (ir[15:12] == 4'h4);
    cls_i  = !cls_r && !cls_m;
    is_ld  = cls_m && (ir[7:4] == 4'h0);
    is_st  = cls_m && (ir[7:4] == 4'h4);
    is_nop = cls_m && !is_ld && !is_st;
  end

  // Last cycle of an instruction: the only point where run is sampled.
  always_comb begin
    retire = 1'b0;
    unique case (state)
      EXEC:    retire = 1'b1;
      WB:      retire = 1'b1;
      MEM:     retire = bus.mem_ready && st_op;
      DECODE:  retire = is_nop;
      default: retire = 1'b0;
    endcase
  end

  assign bus.mem_addr  = (state == MEM) ?
                         addr_reg_data[ADDR_W-1:0] : pc;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      st_op     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      opcode    <= '0;
      rdest     <= '0;
      rsrc      <= '0;
      immediate <= '0;
      use_imm   <= 1'b0;
      reg_we    <= 1'b0;
      wb_sel    <= 1'b0;
      load_data <= '0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            rd_q  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            ir    <= bus.mem_rdata;
            pc    <= pc + ADDR_W'(1);
            rd_q  <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          unique case (1'b1)
            cls_r: begin
              opcode  <= ir[7:4];
              rdest   <= ir[11:8];
              rsrc    <= ir[3:0];
              use_imm <= 1'b0;
            end
            cls_m: begin
              rdest <= ir[11:8];
              rsrc  <= ir[3:0];
            end
            cls_i: begin
              opcode    <= ir[15:12];
              rdest     <= ir[11:8];
              immediate <= ir[7:0];
              use_imm   <= 1'b1;
            end
            default: ;
          endcase
          if (is_ld) begin
            state <= MEM;
            rd_q  <= 1'b1;
            st_op <= 1'b0;
          end else if (is_st) begin
            state <= MEM;
            wr_q  <= 1'b1;
            st_op <= 1'b1;
          end else if (!is_nop) begin
            state  <= EXEC;
            reg_we <= 1'b1;
            wb_sel <= 1'b0;
          end
        end
        MEM: begin
          if (bus.mem_ready && !st_op) begin
            rd_q      <= 1'b0;
            load_data <= bus.mem_rdata;
            state     <= WB;
            reg_we    <= 1'b1;
            wb_sel    <= 1'b1;
          end
        end
        EXEC, WB: ;
        default: state <= IDLE;
      endcase
      // Boundary handling overrides the per-state updates above.
      if (retire) begin
        wr_q <= 1'b0;
        if (run) begin
          state <= FETCH;
          rd_q  <= 1'b1;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          rd_q  <= 1'b0;
          busy  <= 1'b0;
        end
      end
    end
  end

`ifdef SEQ_RETIRE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
